// File: rtl/wdg_pkg.sv
// -----------------------------------------------------------------------------
// wdg_pkg
// Shared definitions for the two-stage watchdog core.
//   STATE_W      : width of the FSM state encoding (2)
//   wdg_state_e  : IDLE=0, COUNT=1, S1=2, S2=3
//   st_running() : true in the states where the prescaler advances
// -----------------------------------------------------------------------------
package wdg_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_S1    = 2'd2,
    ST_S2    = 2'd3
  } wdg_state_e;

  function automatic logic st_running(input wdg_state_e s);
    return (s == ST_COUNT) || (s == ST_S1);
  endfunction

endpackage

// File: rtl/wdg_prescaler.sv
// -----------------------------------------------------------------------------
// wdg_prescaler
// Free-running TICK_BIT+1 bit tick prescaler for the watchdog core.
// Tick period is 2^(TICK_BIT+1) clk cycles.
//   clk  in  system clock
//   res  in  synchronous active-high reset
//   clr  in  restart the period (counter to 0 on the next edge)
//   run  in  advance the counter; counter holds when low
//   tick out one-cycle pulse while the counter sits at its last value
// -----------------------------------------------------------------------------
module wdg_prescaler #(
  parameter int TICK_BIT = 2
) (
  input  logic clk,
  input  logic res,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int PW = TICK_BIT + 1;

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;

  always_comb begin
    presc_d = presc_q;
    if (clr) begin
      presc_d = '0;
    end else if (run) begin
      // Natural wrap from all-ones back to zero ends each period.
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick = run && (presc_q == {PW{1'b1}});

endmodule

// File: rtl/wdg_core_win.sv
// -----------------------------------------------------------------------------
// wdg_core_win
// Two-stage watchdog core: countdown FSM, timeout counter and integrated tick
// prescaler, with optional windowed kick checking.
// Optional feature macro: WDG_WINDOW_EN (enables the early-kick window check;
// without it cfg_win is ignored and win_err is tied to 0).
//   clk         in   system clock
//   res         in   synchronous active-high reset
//   cfg_en      in   watchdog enable level
//   cfg_wtocnt  in   reload value in ticks (0 behaves as 1)
//   cfg_win     in   window bound; kick valid only while cnt <= cfg_win
//   kick        in   single-cycle service strobe
//   clr_s1      in   single-cycle clear of the stage-1 flag
//   clr_s2      in   single-cycle clear of the stage-2 flag
//   cnt         out  current count
//   state       out  FSM state (IDLE/COUNT/S1/S2)
//   win_err     out  sticky early-kick flag
//   irq1        out  stage-1 timeout flag
//   irq2        out  stage-2 timeout flag
// -----------------------------------------------------------------------------
module wdg_core_win
  import wdg_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int TICK_BIT  = 2
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 cfg_en,
  input  logic [CNT_WIDTH-1:0] cfg_wtocnt,
  input  logic [CNT_WIDTH-1:0] cfg_win,
  input  logic                 kick,
  input  logic                 clr_s1,
  input  logic                 clr_s2,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic [STATE_W-1:0]   state,
  output logic                 win_err,
  output logic                 irq1,
  output logic                 irq2
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  wdg_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 irq1_q, irq1_d;
  logic                 irq2_q, irq2_d;
  logic                 werr_q, werr_d;
  logic                 reload;
  logic                 tick;
  logic                 early;
  logic [CNT_WIDTH-1:0] rld_val;

  assign rld_val = (cfg_wtocnt == '0) ? CNT_ONE : cfg_wtocnt;

`ifdef WDG_WINDOW_EN
  assign early = cnt_q > cfg_win;
`else
  logic unused_win;
  assign early      = 1'b0;
  assign unused_win = ^{cfg_win, werr_d};
`endif

  // Every reload restarts the tick period; disabling parks the prescaler at 0.
  wdg_prescaler #(
    .TICK_BIT (TICK_BIT)
  ) u_presc (
    .clk  (clk),
    .res  (res),
    .clr  (!cfg_en || reload),
    .run  (cfg_en && st_running(state_q)),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    irq1_d  = irq1_q;
    irq2_d  = irq2_q;
    werr_d  = werr_q;
    reload  = 1'b0;

    if (!cfg_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Re-enable resumes in the stage implied by the surviving flags,
          // taking same-cycle clears into account.
          reload = 1'b1;
          if (irq2_q && !clr_s2) begin
            state_d = ST_S2;
            cnt_d   = '0;
          end else if (irq1_q && !clr_s1) begin
            state_d = ST_S1;
            cnt_d   = rld_val;
          end else begin
            state_d = ST_COUNT;
            cnt_d   = rld_val;
          end
        end

        ST_COUNT: begin
          // A kick overrides a coincident expiry tick.
          if (kick) begin
            reload = 1'b1;
            cnt_d  = rld_val;
            if (early) begin
              werr_d  = 1'b1;
              irq1_d  = 1'b1;
              state_d = ST_S1;
            end
          end else if (tick) begin
            if (cnt_q > CNT_ONE) begin
              cnt_d = cnt_q - CNT_ONE;
            end else begin
              irq1_d  = 1'b1;
              reload  = 1'b1;
              cnt_d   = rld_val;
              state_d = ST_S1;
            end
          end
        end

        ST_S1: begin
          // Clearing stage 1 wins over a coincident stage-2 expiry.
          if (clr_s1) begin
            reload  = 1'b1;
            cnt_d   = rld_val;
            state_d = ST_COUNT;
          end else if (tick) begin
            if (cnt_q > CNT_ONE) begin
              cnt_d = cnt_q - CNT_ONE;
            end else begin
              irq2_d  = 1'b1;
              cnt_d   = '0;
              state_d = ST_S2;
            end
          end
        end

        ST_S2: begin
          if (clr_s2) begin
            reload  = 1'b1;
            cnt_d   = rld_val;
            irq1_d  = 1'b0;
            state_d = ST_COUNT;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // Software clears take precedence over any flag set in the same cycle.
      if (clr_s1) begin
        irq1_d = 1'b0;
      end
      if (clr_s2) begin
        irq2_d = 1'b0;
      end
      if (clr_s1 || clr_s2) begin
        werr_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      irq1_q  <= 1'b0;
      irq2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      irq1_q  <= irq1_d;
      irq2_q  <= irq2_d;
    end
  end

`ifdef WDG_WINDOW_EN
  always_ff @(posedge clk) begin
    if (res) begin
      werr_q <= 1'b0;
    end else begin
      werr_q <= werr_d;
    end
  end
`else
  assign werr_q = 1'b0;
`endif

  assign cnt     = cnt_q;
  assign state   = state_q;
  assign win_err = werr_q;
  assign irq1    = irq1_q;
  assign irq2    = irq2_q;

endmodule

// File: doc/wdg_core_win.md
# wdg_core_win

Parametrised two-stage watchdog core with configurable counter width, integrated tick prescaler and optional windowed kick checking. It sits behind the watchdog register file and replaces the separate FSM/counter/clock-divider trio. It takes configuration and software strobes as plain signals and drives the stage-1/stage-2 timeout flags and interrupts. All logic runs on `clk`; there is no derived clock.

## Interface
- `CNT_WIDTH`, 16: width of the timeout counter and of `cfg_wtocnt` / `cfg_win`.
- `TICK_BIT`, 2: prescaler width is TICK_BIT+1; tick period P = 2^(TICK_BIT+1) clk cycles.

- `clk`  in  1  system clock.
- `res`  in  1  reset. **Synchronous, active-high.**
- `cfg_en`  in  1  watchdog enable level.
- `cfg_wtocnt`  in  CNT_WIDTH  reload value in ticks; 0 is treated as 1.
- `cfg_win`  in  CNT_WIDTH  window bound; a kick is valid only when `cnt <= cfg_win`.
- `kick`  in  1  single-cycle service strobe.
- `clr_s1`  in  1  single-cycle write-clear of the stage-1 flag.
- `clr_s2`  in  1  single-cycle write-clear of the stage-2 flag.
- `cnt`  out  CNT_WIDTH  current count, readable by software.
- `state`  out  2  FSM state encoding.
- `win_err`  out  1  sticky early-kick flag.
- `irq1`  out  1  stage-1 timeout flag (s1wto).
- `irq2`  out  1  stage-2 timeout flag (s2wto).

## Operation
- States:
  - IDLE=0: `cfg_en` low.
  - COUNT=1: normal countdown.
  - S1=2: stage 1 expired, counting again.
  - S2=3: stage 2 expired, counter frozen.
- Reset: state IDLE; `cnt`, prescaler, `irq1`, `irq2` and `win_err` all 0.
- Any state, `cfg_en`=0 → IDLE next cycle. `cnt` is held, flags are held, prescaler is cleared.
- IDLE with `cfg_en`=1 → reload (`cnt`=max(cfg_wtocnt,1), prescaler=0). Next state is S2 if irq2 is set, else S1 if irq1 is set, else COUNT. In S2, `cnt` is 0 instead of the reload value.
- Tick: one-cycle pulse when prescaler == P-1 in COUNT or S1. The prescaler wraps to 0 and is frozen in IDLE and S2.
- On each tick, in COUNT or S1:
  - if `cnt` > 1, decrement;
  - if `cnt` == 1, expire.
- Expiry in COUNT: set irq1, reload, go to S1.
- Expiry in S1: set irq2, `cnt`=0, go to S2.
- Kick in COUNT:
  - Valid kick: reload, stay in COUNT.
  - Early kick (window enabled, `cnt` > `cfg_win`): set win_err and irq1, reload, go to S1.
- Kick in S1, S2 or IDLE: ignored.
- `clr_s1`:
  - in S1: clear irq1, reload, go to COUNT;
  - elsewhere: clear irq1 only, state unchanged.
- `clr_s2`:
  - in S2: clear irq2 and irq1, reload, go to COUNT;
  - elsewhere: clear irq2 only.
- `win_err` is cleared only by `clr_s1` or `clr_s2`.
- Simultaneous events, in priority order: res > `cfg_en`=0 > clr strobe > kick > tick expiry.
  - Kick and expiry in the same cycle: the kick result applies, so a valid kick reloads.
  - `clr_s1` and expiry in the same cycle in S1: return to COUNT, irq2 not set.
- `cfg_wtocnt` changes take effect only at the next reload.

## Timing
- All outputs are registered. Flags and `cnt` update in the cycle after the triggering edge.
- `cfg_en` is sampled high in cycle E:
  - reload is visible at E+1;
  - ticks occur at E+kP;
  - stage-1 expiry tick is at E+wtocnt·P, and `irq1` is high from E+wtocnt·P+1.
- After irq1, `irq2` rises wtocnt·P cycles later unless `clr_s1` arrives first.
- A kick at cycle K restarts the period: the next tick is at K+P.

## Configuration
- Macro `WDG_WINDOW_EN`.
- Defined: window check as described above.
- Undefined:
  - `cfg_win` is ignored;
  - every kick in COUNT is valid;
  - `win_err` is tied to 0;
  - no comparator is synthesised.

## Structure
- Package `wdg_pkg` holds:
  - the state typedef/encoding (IDLE/COUNT/S1/S2);
  - the `STATE_W`=2 constant.
- Sub-module `wdg_prescaler`: TICK_BIT+1 bit counter with `clr`/`run` inputs and a `tick` output.
- The FSM and counter stay in `wdg_core_win`.

## Test plan
- Stage-1 timeout. Stimulus: TICK_BIT=0, wtocnt=4, enable at E, no kicks. Response: `irq1` rises at E+9, `cnt`=4, state=S1.
- Stage-2 timeout. Stimulus: continue the stage-1 case with no clear. Response: `irq2` rises at E+17, `cnt`=0, state=S2, `cnt` frozen.
- Periodic service. Stimulus: wtocnt=4, kick every 6 cycles for 100 cycles. Response: `irq1` stays 0, `cnt` never falls below 2.
- Window check. Stimulus: `WDG_WINDOW_EN` defined, wtocnt=8, win=3, kick while `cnt`=6. Response: `win_err`=1, `irq1`=1, state S1. Without the macro, the same kick simply reloads to 8.
- Clear and disable.
  - `clr_s1` coincident with the S1 expiry tick: state → COUNT, `irq2` stays 0.
  - `clr_s2` in S2: both flags 0, `cnt`=wtocnt.
- Reset and re-enable.
  - `cfg_en`=0 mid-count with irq1 set, then re-enable: state → S1.
  - `res` pulse: all outputs 0 on the next cycle.
